// File: rtl/multi_channel_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to NUM_CH request/response channels,
// returning one in-order result per command with error/timeout reporting and an error counter.
module multi_channel_cmd_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 256,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CW  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CHW-1:0]           cmd_ch,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_ready,
  output logic                     req_write,
  output logic [ADDR_W-1:0]        req_addr,
  output logic [DATA_W-1:0]        req_wdata,
  input  logic [NUM_CH-1:0]        rsp_valid,
  input  logic [NUM_CH-1:0]        rsp_err,
  input  logic [NUM_CH*DATA_W-1:0] rsp_rdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CHW-1:0]           res_ch,
  output logic [DATA_W-1:0]        res_rdata,
  output logic                     res_err,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [CW-1:0]            fifo_count,
  output logic [15:0]              err_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, POP, ISSUE, WAIT_RSP, REPORT} state_t;

  state_t state, next_state;

  logic [CHW-1:0]    fifo_ch    [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic [CHW-1:0]    cur_ch;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [TW-1:0]     timer;

  logic              push, pop, fifo_avail, ch_ok;
  logic [CHW-1:0]    head_ch;
  logic [NUM_CH-1:0] ch_sel;
  logic              req_hs, rsp_hit, rsp_err_sel, timeout_hit;
  logic [DATA_W-1:0] rsp_data_sel;

  assign cmd_ready  = (count < CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == POP);
  // An incoming push counts as available so an idle sequencer reaches ISSUE two cycles after the push.
  assign fifo_avail = (count != '0) || push;
  assign head_ch    = fifo_ch[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);

  if (NUM_CH == (1 << CHW)) begin : g_all_codes_valid
    assign ch_ok = 1'b1;
  end else begin : g_range_check
    assign ch_ok = (head_ch < CHW'(NUM_CH));
  end

  assign ch_sel       = NUM_CH'(1) << cur_ch;
  assign req_hs       = (state == ISSUE) && ((req_ready & ch_sel) != '0);
  assign rsp_hit      = (state == WAIT_RSP) && ((rsp_valid & ch_sel) != '0);
  assign rsp_err_sel  = (rsp_err & ch_sel) != '0;
  assign rsp_data_sel = rsp_rdata[int'(cur_ch)*DATA_W +: DATA_W];
  assign timeout_hit  = (timer == TW'(TIMEOUT_CYC - 2));

  assign req_valid = (state == ISSUE) ? ch_sel : '0;
  assign req_write = cur_write;
  assign req_addr  = cur_addr;
  assign req_wdata = cur_wdata;
  assign res_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ch[wr_ptr]    <= cmd_ch;
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (fifo_avail) next_state = POP;
      POP:      next_state = ch_ok ? ISSUE : REPORT;
      ISSUE:    if (req_hs) next_state = WAIT_RSP;
      WAIT_RSP: if (rsp_hit || timeout_hit) next_state = REPORT;
      REPORT:   if (res_ready) next_state = fifo_avail ? POP : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // A response in the final wait cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch      <= '0;
      cur_write   <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      timer       <= '0;
      res_ch      <= '0;
      res_rdata   <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        POP: begin
          cur_ch      <= head_ch;
          cur_write   <= fifo_write[rd_ptr];
          cur_addr    <= fifo_addr[rd_ptr];
          cur_wdata   <= fifo_wdata[rd_ptr];
          res_ch      <= head_ch;
          res_rdata   <= '0;
          res_err     <= !ch_ok;
          res_timeout <= 1'b0;
        end
        ISSUE: timer <= '0;
        WAIT_RSP: begin
          timer <= timer + TW'(1);
          if (rsp_hit) begin
            res_err   <= rsp_err_sel;
            res_rdata <= (cur_write || rsp_err_sel) ? '0 : rsp_data_sel;
          end else if (timeout_hit) begin
            res_err     <= 1'b1;
            res_timeout <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready && res_err && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus randomized batches, checked against a
// transaction-level model of results, issued requests and the error counter.
module tb_multi_channel_cmd_sequencer;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 16;
  localparam int CHW = 2;
  localparam int CW  = 4;

  typedef struct packed {logic [1:0] ch; logic [31:0] rdata; logic err; logic tmo;} res_t;
  typedef struct packed {logic [3:0] ch; logic wr; logic [31:0] addr; logic [31:0] wdata;} req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [CHW-1:0] cmd_ch;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [NCH-1:0] req_valid, req_ready, rsp_valid, rsp_err;
  logic req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NCH*DW-1:0] rsp_rdata;
  logic res_valid, res_ready, res_err, res_timeout, busy;
  logic [CHW-1:0] res_ch;
  logic [DW-1:0] res_rdata;
  logic [CW-1:0] fifo_count;
  logic [15:0] err_count;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int res_seen_cyc = 0;
  bit stall = 0, rand_ready = 0, noise = 0, echo = 0, err_on = 0, drop = 0;
  int rsp_lat = 0;
  logic [15:0] model_err = '0;
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  req_t req_log[$];
  req_t exp_req[$];
  res_t exp_res[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_channel_cmd_sequencer #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_rdata(res_rdata),
    .res_err(res_err), .res_timeout(res_timeout), .busy(busy),
    .fifo_count(fifo_count), .err_count(err_count)
  );

  // Channel device model: decides ready, logs handshakes, answers after a latency, injects stray responses.
  initial begin : responder
    int pend_cnt, pend_ch, n, hc;
    logic pend_wr, e;
    logic [31:0] pend_addr, pend_wdata, d;
    pend_cnt = 0; pend_ch = 0; pend_wr = 0; pend_addr = '0; pend_wdata = '0;
    req_ready = '0; rsp_valid = '0; rsp_err = '0; rsp_rdata = '0;
    forever begin
      @(negedge clk);
      rsp_valid = '0; rsp_err = '0; rsp_rdata = '0;
      if (!rst_n) pend_cnt = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          e = err_on && (pend_addr[5:4] == 2'b11);
          if (!e && pend_wr) dev_mem[pend_addr] = pend_wdata;
          d = dev_mem.exists(pend_addr) ? dev_mem[pend_addr] : ~pend_addr;
          rsp_valid[pend_ch] = 1'b1;
          rsp_err[pend_ch] = e;
          rsp_rdata[pend_ch*DW +: DW] = d;
          if (echo) begin
            for (int c = 0; c < NCH; c++) begin
              if (c != pend_ch) begin
                rsp_valid[c] = 1'b1;
                rsp_err[c] = 1'($urandom);
                rsp_rdata[c*DW +: DW] = $urandom;
              end
            end
          end
        end
      end
      if (noise && ($urandom_range(0, 2) == 0)) begin
        n = $urandom_range(0, NCH - 1);
        if (!rsp_valid[n] && !(pend_cnt > 0 && n == pend_ch)) begin
          rsp_valid[n] = 1'b1;
          rsp_err[n] = 1'($urandom);
          rsp_rdata[n*DW +: DW] = $urandom;
        end
      end
      req_ready = stall ? '0 : (rand_ready ? NCH'($urandom) : '1);
      if (rst_n && ((req_valid & req_ready) != '0)) begin
        hc = 15;
        if ($countones(req_valid) == 1)
          for (int c = 0; c < NCH; c++) if (req_valid[c]) hc = c;
        req_log.push_back('{4'(hc), req_write, req_addr, req_wdata});
        pend_ch = hc; pend_wr = req_write; pend_addr = req_addr; pend_wdata = req_wdata;
        pend_cnt = drop ? 0 : ((rsp_lat != 0) ? rsp_lat : $urandom_range(1, 4));
        hs_cyc = cyc + 1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Predicts the result (and issued request) of one command from the channel rules.
  function automatic void model_cmd(input int ch, input bit wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input bit tmo);
    res_t r;
    r = '{2'(ch), 32'h0, 1'b0, 1'b0};
    if (ch >= NCH) r.err = 1'b1;
    else begin
      exp_req.push_back('{4'(ch), wr, addr, wdata});
      if (tmo) begin
        r.err = 1'b1; r.tmo = 1'b1;
      end else begin
        r.err = err_on && (addr[5:4] == 2'b11);
        if (!r.err) begin
          if (wr) model_mem[addr] = wdata;
          else r.rdata = model_mem.exists(addr) ? model_mem[addr] : ~addr;
        end
      end
    end
    exp_res.push_back(r);
  endfunction

  task automatic apply_stimulus(input int ch, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit use_model, input bit tmo);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      ok = cmd_ready;
    end
    if (!ok) check_output("push_accept", 80'(ok), 80'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (ok && use_model) model_cmd(ch, wr, addr, wdata, tmo);
  endtask

  task automatic take_result(input bit rnd, input int hold, input string tag);
    bit got;
    int vcnt;
    res_t e, o;
    got = 0; vcnt = 0; o = '0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        if (vcnt == 0) res_seen_cyc = cyc;
        vcnt++;
        res_ready = (vcnt > hold) && (!rnd || ($urandom_range(0, 2) != 0));
        if (res_ready) begin
          got = 1;
          o = '{res_ch, res_rdata, res_err, res_timeout};
        end
      end else begin
        res_ready = 1'b0;
      end
    end
    check_output({tag, "_got"}, 80'(got), 80'd1);
    if (got) begin
      @(posedge clk);
      #1 res_ready = 1'b0;
      if (exp_res.size() == 0) check_output({tag, "_extra"}, 80'(exp_res.size()), 80'd1);
      else begin
        e = exp_res.pop_front();
        check_output({tag, "_ch"}, 80'(o.ch), 80'(e.ch));
        check_output({tag, "_rdata"}, 80'(o.rdata), 80'(e.rdata));
        check_output({tag, "_err"}, 80'(o.err), 80'(e.err));
        check_output({tag, "_timeout"}, 80'(o.tmo), 80'(e.tmo));
        if (e.err && model_err != 16'hFFFF) model_err++;
      end
      @(negedge clk);
      check_output({tag, "_err_count"}, 80'(err_count), 80'(model_err));
    end else begin
      res_ready = 1'b0;
    end
  endtask

  task automatic check_requests(input string tag);
    check_output({tag, "_req_count"}, 80'(req_log.size()), 80'(exp_req.size()));
    for (int i = 0; i < req_log.size() && i < exp_req.size(); i++)
      check_output({tag, "_req"}, 80'(req_log[i]), 80'(exp_req[i]));
    req_log.delete();
    exp_req.delete();
  endtask

  initial begin : main
    int n;
    cmd_valid = 0; cmd_ch = '0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; res_ready = 0;
    dev_mem[32'h40] = 32'hDEADBEEF;
    model_mem[32'h40] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check_output("rst_cmd_ready", 80'(cmd_ready), 80'd1);
    check_output("rst_req_valid", 80'(req_valid), 80'd0);
    check_output("rst_res_valid", 80'(res_valid), 80'd0);
    check_output("rst_busy", 80'(busy), 80'd0);
    check_output("rst_fifo_count", 80'(fifo_count), 80'd0);
    check_output("rst_err_count", 80'(err_count), 80'd0);
    rst_n = 1'b1;

    // Write to ch1: request appears two cycles after the push.
    rsp_lat = 3;
    apply_stimulus(1, 1'b1, 32'h100, 32'hA5A5A5A5, 1, 0);
    @(negedge clk);
    check_output("lat_cycle1_req_valid", 80'(req_valid), 80'd0);
    @(negedge clk);
    check_output("lat_cycle2_req_valid", 80'(req_valid), 80'b010);
    check_output("lat_req_addr", 80'(req_addr), 80'h100);
    check_output("lat_req_wdata", 80'(req_wdata), 80'hA5A5A5A5);
    take_result(0, 0, "wr_ch1");

    // Read ch0 while other channels answer at the same moment.
    echo = 1;
    apply_stimulus(0, 1'b0, 32'h40, 32'h0, 1, 0);
    take_result(0, 2, "rd_ch0");
    echo = 0;
    check_requests("basic");

    // Response in the last wait cycle beats the timeout; one cycle later it does not.
    rsp_lat = TMO - 1;
    apply_stimulus(0, 1'b0, 32'h44, 32'h0, 1, 0);
    take_result(0, 0, "last_cycle_rsp");
    check_output("last_cycle_wait_len", 80'(res_seen_cyc - hs_cyc), 80'(TMO - 1));
    rsp_lat = TMO;
    apply_stimulus(0, 1'b0, 32'h48, 32'h0, 1, 1);
    take_result(0, 4, "timeout");
    check_output("timeout_wait_len", 80'(res_seen_cyc - hs_cyc), 80'(TMO - 1));
    check_requests("timeout");

    // Channel code beyond NUM_CH is rejected without a request; the next command still runs.
    rsp_lat = 2;
    apply_stimulus(3, 1'b1, 32'h80, 32'h11112222, 1, 0);
    apply_stimulus(2, 1'b0, 32'h84, 32'h0, 1, 0);
    take_result(0, 0, "bad_ch");
    take_result(0, 0, "after_bad_ch");
    check_requests("bad_ch");

    // Fill the FIFO behind a stalled channel.
    stall = 1;
    for (int i = 0; i < 9; i++)
      apply_stimulus(i % NCH, 1'(i % 2), 32'h200 + 32'(4 * i), 32'(i * 32'h01010101), 1, 0);
    @(negedge clk);
    check_output("full_cmd_ready", 80'(cmd_ready), 80'd0);
    check_output("full_fifo_count", 80'(fifo_count), 80'd8);
    check_output("full_busy", 80'(busy), 80'd1);
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_write = 1'b1; cmd_addr = 32'h2FC; cmd_wdata = 32'hBAD0BAD0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check_output("full_reject_count", 80'(fifo_count), 80'd8);
    stall = 0;
    for (int i = 0; i < 9; i++) take_result(1, 0, "drain");
    check_output("drain_fifo_count", 80'(fifo_count), 80'd0);
    check_output("drain_busy", 80'(busy), 80'd0);
    check_requests("drain");

    // Randomized batches with errors, random handshakes and stray responses.
    err_on = 1; rand_ready = 1; noise = 1; rsp_lat = 0;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 8);
      echo = 1'($urandom);
      for (int i = 0; i < n; i++)
        apply_stimulus($urandom_range(0, 3), 1'($urandom), 32'h200 + 32'(4 * $urandom_range(0, 15)),
                       $urandom, 1, 0);
      for (int i = 0; i < n; i++) take_result(1, $urandom_range(0, 1), "rand");
      check_requests("rand");
    end
    err_on = 0; rand_ready = 0; noise = 0; echo = 0;

    // Reset while a read waits for a response that never comes.
    drop = 1;
    apply_stimulus(0, 1'b0, 32'h300, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1'b1, 32'h304, 32'h0, 0, 0);
    repeat (3) @(negedge clk);
    check_output("mid_reset_issued", 80'(req_log.size()), 80'd1);
    req_log.delete();
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_reset_req_valid", 80'(req_valid), 80'd0);
    check_output("mid_reset_res_valid", 80'(res_valid), 80'd0);
    check_output("mid_reset_fifo_count", 80'(fifo_count), 80'd0);
    check_output("mid_reset_err_count", 80'(err_count), 80'd0);
    check_output("mid_reset_cmd_ready", 80'(cmd_ready), 80'd1);
    model_err = '0;
    drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("post_reset_res_valid", 80'(res_valid), 80'd0);
    check_output("post_reset_busy", 80'(busy), 80'd0);
    check_output("post_reset_no_req", 80'(req_log.size()), 80'd0);

    rsp_lat = 1;
    apply_stimulus(2, 1'b1, 32'h308, 32'h12345678, 1, 0);
    apply_stimulus(2, 1'b0, 32'h308, 32'h0, 1, 0);
    take_result(0, 0, "recover_wr");
    take_result(0, 0, "recover_rd");
    check_requests("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
